// File: rtl/ftdi_sync_fifo_ctrl.sv
// ftdi_sync_fifo_ctrl: FT245 synchronous-mode FIFO controller.
// Runs bursted reads from the FTDI into a small RX buffer that feeds a
// valid/ready stream. Runs bursted writes from a valid/ready stream through
// a one-entry hold register. Arbitration between the two directions is
// either fixed (RX wins) or round-robin.
module ftdi_sync_fifo_ctrl #(
  parameter int unsigned DW        = 8,
  parameter int unsigned RX_BUF    = 4,
  parameter int unsigned MAX_BURST = 64,
  parameter int unsigned PRIORITY  = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rxf,
  input  logic          txe,
  output logic          oe,
  output logic          rd,
  output logic          wr,
  input  logic [DW-1:0] ftdi_data_i,
  output logic [DW-1:0] ftdi_data_o,
  output logic          ftdi_data_oe,
  output logic [DW-1:0] rx_data,
  output logic          rx_valid,
  input  logic          rx_ready,
  input  logic [DW-1:0] tx_data,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic          busy
);

  localparam int unsigned AW = $clog2(RX_BUF);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] BUF_FULL  = CW'(RX_BUF);
  localparam logic [15:0]   BURST_MAX = 16'(MAX_BURST);

  typedef enum logic [2:0] {
    IDLE,
    RD_TURN,
    RD_BURST,
    WR_BURST,
    TURN
  } state_t;

  state_t        state_q;
  logic          oe_q, rd_q, wr_q, doe_q;
  logic [DW-1:0] dout_q;
  logic          hold_valid_q, hold_valid_d;
  logic          pref_tx_q;
  logic [15:0]   cnt_q;
  logic [15:0]   rd_cnt_d, wr_cnt_d;

  logic [DW-1:0] mem_q [RX_BUF];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;

  logic push, pop, accept, load, tx_rdy;
  logic rx_req, tx_req, grant_tx;
  logic rd_more, wr_exit;

  assign oe           = oe_q;
  assign rd           = rd_q;
  assign wr           = wr_q;
  assign ftdi_data_o  = dout_q;
  assign ftdi_data_oe = doe_q;
  assign rx_valid     = (count_q != '0);
  assign rx_data      = mem_q[rptr_q];
  assign tx_ready     = tx_rdy;
  assign busy         = (state_q != IDLE);

  // Transfer qualifiers, burst continuation and arbitration decisions
  always_comb begin
    push     = !rd_q && !rxf;
    pop      = rx_valid && rx_ready;
    count_d  = count_q + CW'(push) - CW'(pop);
    rd_cnt_d = cnt_q + 16'(push);
    // Keep strobing only if the next byte is guaranteed a free slot
    rd_more  = !rxf && (count_d < BUF_FULL) && (rd_cnt_d < BURST_MAX);

    accept       = !wr_q && !txe;
    tx_rdy       = (state_q == WR_BURST) && (!hold_valid_q || accept);
    load         = tx_valid && tx_rdy;
    hold_valid_d = load || (hold_valid_q && !accept);
    wr_cnt_d     = cnt_q + 16'(accept);
    wr_exit      = txe || (wr_cnt_d >= BURST_MAX) || (!hold_valid_q && !tx_valid);

    rx_req = !rxf && (count_q != BUF_FULL);
    tx_req = !txe && (tx_valid || hold_valid_q);
    if (PRIORITY == 0) grant_tx = tx_req && !rx_req;
    else               grant_tx = tx_req && (!rx_req || pref_tx_q);
  end

  // RX buffer storage and occupancy; pointers wrap at the power-of-2 depth
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= ftdi_data_i;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (pop) rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // TX hold register; an unaccepted byte survives until a later grant sends it
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      dout_q       <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      if (load) dout_q <= tx_data;
    end
  end

  // Bus sequencing FSM with registered FTDI-side strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      oe_q      <= 1'b1;
      rd_q      <= 1'b1;
      wr_q      <= 1'b1;
      doe_q     <= 1'b0;
      cnt_q     <= '0;
      pref_tx_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant_tx) begin
            state_q   <= WR_BURST;
            doe_q     <= 1'b1;
            wr_q      <= !hold_valid_d;
            cnt_q     <= '0;
            pref_tx_q <= 1'b0;
          end else if (rx_req) begin
            state_q   <= RD_TURN;
            oe_q      <= 1'b0;
            cnt_q     <= '0;
            pref_tx_q <= 1'b1;
          end
        end
        RD_TURN: begin
          state_q <= RD_BURST;
          rd_q    <= 1'b0;
        end
        RD_BURST: begin
          cnt_q <= rd_cnt_d;
          if (!rd_more) begin
            rd_q    <= 1'b1;
            oe_q    <= 1'b1;
            state_q <= TURN;
          end
        end
        WR_BURST: begin
          cnt_q <= wr_cnt_d;
          if (wr_exit) begin
            wr_q    <= 1'b1;
            doe_q   <= 1'b0;
            state_q <= TURN;
          end else begin
            wr_q <= !hold_valid_d;
          end
        end
        TURN: begin
          oe_q    <= 1'b1;
          rd_q    <= 1'b1;
          wr_q    <= 1'b1;
          doe_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ftdi_sync_fifo_ctrl.sv
// tb_ftdi_sync_fifo_ctrl: directed bench for the FTDI sync FIFO controller.
// Instance 0: defaults. Instance 1: round-robin, MAX_BURST=4.
// Instance 2: MAX_BURST=1. Each instance has its own FTDI host and
// stream source/sink models.
`timescale 1ns/1ps
module tb_ftdi_sync_fifo_ctrl;
  localparam int N = 3;

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic mdl_clr = 1'b1;
  always #5 clk = ~clk;

  logic       rxf [N];
  logic       txe [N];
  logic       oe [N];
  logic       rd [N];
  logic       wr [N];
  logic       doe [N];
  logic [7:0] din [N];
  logic [7:0] dout [N];
  logic [7:0] rx_data [N];
  logic       rx_valid [N];
  logic       rx_ready [N];
  logic [7:0] tx_data [N];
  logic       tx_valid [N];
  logic       tx_ready [N];
  logic       busy [N];

  int         rx_idx [N];
  int         rx_lim [N];
  int         rx_n [N];
  int         tx_idx [N];
  int         tx_lim [N];
  int         tx_n [N];
  logic [7:0] rx_base [N];
  logic [7:0] tx_base [N];
  logic [7:0] rx_got [N][64];
  logic [7:0] tx_log [N][64];

  int n_tests = 0;
  int n_fail  = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int unsigned P  = (g == 1) ? 1 : 0;
    localparam int unsigned MB = (g == 0) ? 64 : ((g == 1) ? 4 : 1);

    ftdi_sync_fifo_ctrl #(
      .DW(8),
      .RX_BUF(4),
      .MAX_BURST(MB),
      .PRIORITY(P)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .rxf(rxf[g]),
      .txe(txe[g]),
      .oe(oe[g]),
      .rd(rd[g]),
      .wr(wr[g]),
      .ftdi_data_i(din[g]),
      .ftdi_data_o(dout[g]),
      .ftdi_data_oe(doe[g]),
      .rx_data(rx_data[g]),
      .rx_valid(rx_valid[g]),
      .rx_ready(rx_ready[g]),
      .tx_data(tx_data[g]),
      .tx_valid(tx_valid[g]),
      .tx_ready(tx_ready[g]),
      .busy(busy[g])
    );

    assign rxf[g]      = !(rx_idx[g] < rx_lim[g]);
    assign din[g]      = rx_base[g] + 8'(rx_idx[g]);
    assign tx_valid[g] = (tx_idx[g] < tx_lim[g]);
    assign tx_data[g]  = tx_base[g] + 8'(tx_idx[g]);
  end

  // FTDI host and stream endpoint models
  always @(posedge clk) begin
    for (int g = 0; g < N; g++) begin
      if (mdl_clr) begin
        rx_idx[g] <= 0;
        rx_n[g]   <= 0;
        tx_idx[g] <= 0;
        tx_n[g]   <= 0;
      end else begin
        if (!rd[g] && !rxf[g]) rx_idx[g] <= rx_idx[g] + 1;
        if (tx_valid[g] && tx_ready[g]) tx_idx[g] <= tx_idx[g] + 1;
        if (!wr[g] && !txe[g]) begin
          if (tx_n[g] < 64) tx_log[g][tx_n[g]] <= dout[g];
          tx_n[g] <= tx_n[g] + 1;
        end
        if (rx_valid[g] && rx_ready[g]) begin
          if (rx_n[g] < 64) rx_got[g][rx_n[g]] <= rx_data[g];
          rx_n[g] <= rx_n[g] + 1;
        end
      end
    end
  end

  task automatic start_test();
    for (int g = 0; g < N; g++) begin
      rx_lim[g]   = 0;
      tx_lim[g]   = 0;
      txe[g]      = 1'b1;
      rx_ready[g] = 1'b0;
      rx_base[g]  = 8'h00;
      tx_base[g]  = 8'h00;
    end
    rst     = 1'b1;
    mdl_clr = 1'b1;
    repeat (2) @(negedge clk);
    rst     = 1'b0;
    mdl_clr = 1'b0;
  endtask

  task automatic test_reset();
    start_test();
    for (int g = 0; g < N; g++) begin
      n_tests++;
      if ({oe[g], rd[g], wr[g], doe[g], rx_valid[g], tx_ready[g], busy[g]} !== 7'b1110000) begin
        n_fail++;
        $display("FAIL reset_ctrl[%0d]: got %b, expected 1110000", g,
                 {oe[g], rd[g], wr[g], doe[g], rx_valid[g], tx_ready[g], busy[g]});
      end
      n_tests++;
      if (dout[g] !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_dout[%0d]: got %h, expected 00", g, dout[g]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int t;
    start_test();
    rx_base[0] = 8'h40;
    rx_lim[0]  = 10;
    t = 0;
    while (rx_idx[0] != 3 && t < 20) begin
      @(negedge clk);
      t++;
    end
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({oe[0], rd[0], rx_valid[0], busy[0]} !== 4'b1100) begin
      n_fail++;
      $display("FAIL midrst_state: got oe,rd,rx_valid,busy=%b, expected 1100",
               {oe[0], rd[0], rx_valid[0], busy[0]});
    end
    rst         = 1'b0;
    rx_ready[0] = 1'b1;
    repeat (40) @(negedge clk);
    n_tests++;
    if (rx_n[0] != 6) begin
      n_fail++;
      $display("FAIL midrst_count: got %0d, expected 6", rx_n[0]);
    end
    n_tests++;
    if (rx_got[0][0] !== 8'h44) begin
      n_fail++;
      $display("FAIL midrst_first: got %h, expected 44", rx_got[0][0]);
    end
    n_tests++;
    if (rx_got[0][5] !== 8'h49) begin
      n_fail++;
      $display("FAIL midrst_last: got %h, expected 49", rx_got[0][5]);
    end
  endtask

  task automatic test_rx_burst();
    int t;
    int low;
    start_test();
    rx_ready[0] = 1'b1;
    rx_base[0]  = 8'h10;
    rx_lim[0]   = 16;
    t = 0;
    while (oe[0] !== 1'b0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    n_tests++;
    if (oe[0] !== 1'b0 || rd[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL rx_turn: got oe=%b rd=%b, expected oe=0 rd=1", oe[0], rd[0]);
    end
    @(negedge clk);
    n_tests++;
    if (rd[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rx_first_rd: got %b, expected 0", rd[0]);
    end
    low = 0;
    t   = 0;
    while (rd[0] === 1'b0 && t < 40) begin
      low++;
      @(negedge clk);
      t++;
    end
    n_tests++;
    if (low != 17) begin
      n_fail++;
      $display("FAIL rx_rd_low: got %0d cycles, expected 17", low);
    end
    n_tests++;
    if ({busy[0], oe[0], rd[0], doe[0]} !== 4'b1110) begin
      n_fail++;
      $display("FAIL rx_end_turn: got busy,oe,rd,doe=%b, expected 1110",
               {busy[0], oe[0], rd[0], doe[0]});
    end
    @(negedge clk);
    n_tests++;
    if (busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rx_end_idle: got busy=%b, expected 0", busy[0]);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (rx_n[0] != 16) begin
      n_fail++;
      $display("FAIL rx_count: got %0d, expected 16", rx_n[0]);
    end
    for (int i = 0; i < 16; i++) begin
      n_tests++;
      if (rx_got[0][i] !== 8'(8'h10 + i)) begin
        n_fail++;
        $display("FAIL rx_data[%0d]: got %h, expected %h", i, rx_got[0][i], 8'(8'h10 + i));
      end
    end
  endtask

  task automatic test_rx_backpressure();
    bit seen;
    start_test();
    rx_base[0] = 8'h10;
    rx_lim[0]  = 10;
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (!seen && rx_idx[0] >= 4) begin
        seen = 1'b1;
        n_tests++;
        if (rd[0] !== 1'b1) begin
          n_fail++;
          $display("FAIL bp_rd_at_4: got rd=%b, expected 1", rd[0]);
        end
      end
    end
    n_tests++;
    if (rx_idx[0] != 4) begin
      n_fail++;
      $display("FAIL bp_captured: got %0d, expected 4", rx_idx[0]);
    end
    n_tests++;
    if ({rx_valid[0], busy[0]} !== 2'b10) begin
      n_fail++;
      $display("FAIL bp_hold: got rx_valid,busy=%b, expected 10", {rx_valid[0], busy[0]});
    end
    rx_ready[0] = 1'b1;
    repeat (60) @(negedge clk);
    n_tests++;
    if (rx_n[0] != 10) begin
      n_fail++;
      $display("FAIL bp_count: got %0d, expected 10", rx_n[0]);
    end
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if (rx_got[0][i] !== 8'(8'h10 + i)) begin
        n_fail++;
        $display("FAIL bp_data[%0d]: got %h, expected %h", i, rx_got[0][i], 8'(8'h10 + i));
      end
    end
  endtask

  task automatic test_tx_stall();
    bit stalled;
    int t;
    start_test();
    txe[0]     = 1'b0;
    tx_base[0] = 8'hA0;
    tx_lim[0]  = 8;
    stalled = 1'b0;
    t = 0;
    while (!stalled && t < 60) begin
      @(negedge clk);
      t++;
      if (wr[0] === 1'b0 && dout[0] === 8'hA3) stalled = 1'b1;
    end
    n_tests++;
    if (!stalled) begin
      n_fail++;
      $display("FAIL tx_reach_a3: got no wr=0 on A3 within 60 cycles, expected one");
    end
    txe[0] = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({wr[0], doe[0], busy[0]} !== 3'b101) begin
      n_fail++;
      $display("FAIL tx_stall_exit: got wr,doe,busy=%b, expected 101", {wr[0], doe[0], busy[0]});
    end
    n_tests++;
    if (tx_n[0] != 3) begin
      n_fail++;
      $display("FAIL tx_stall_sent: got %0d, expected 3", tx_n[0]);
    end
    repeat (3) @(negedge clk);
    txe[0] = 1'b0;
    repeat (30) @(negedge clk);
    n_tests++;
    if (tx_n[0] != 8) begin
      n_fail++;
      $display("FAIL tx_count: got %0d, expected 8", tx_n[0]);
    end
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (tx_log[0][i] !== 8'(8'hA0 + i)) begin
        n_fail++;
        $display("FAIL tx_data[%0d]: got %h, expected %h", i, tx_log[0][i], 8'(8'hA0 + i));
      end
    end
    n_tests++;
    if ({busy[0], doe[0]} !== 2'b00) begin
      n_fail++;
      $display("FAIL tx_end_idle: got busy,doe=%b, expected 00", {busy[0], doe[0]});
    end
  endtask

  task automatic test_arb_rr();
    int dir [8];
    int len [8];
    int ng;
    int cur;
    int d;
    int viol;
    int gapbad;
    bit gap;
    start_test();
    rx_ready[1] = 1'b1;
    rx_lim[1]   = 1000;
    txe[1]      = 1'b0;
    tx_lim[1]   = 1000;
    ng = 0; cur = -1; viol = 0; gapbad = 0; gap = 1'b0;
    for (int c = 0; c < 90; c++) begin
      @(negedge clk);
      if (doe[1] === 1'b1 && oe[1] === 1'b0) viol++;
      d = -1;
      if (rd[1] === 1'b0 && rxf[1] === 1'b0) d = 0;
      else if (wr[1] === 1'b0 && txe[1] === 1'b0) d = 1;
      if (d < 0) begin
        if (oe[1] === 1'b1 && doe[1] === 1'b0 && busy[1] === 1'b1) gap = 1'b1;
      end else begin
        if (d != cur) begin
          if (cur >= 0 && !gap) gapbad++;
          if (ng < 8) begin
            dir[ng] = d;
            len[ng] = 0;
          end
          ng++;
          cur = d;
        end
        if (ng <= 8) len[ng-1]++;
        gap = 1'b0;
      end
    end
    n_tests++;
    if (ng < 4) begin
      n_fail++;
      $display("FAIL rr_bursts: got %0d bursts, expected at least 4", ng);
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_tests++;
        if (dir[k] != (k % 2) || len[k] != 4) begin
          n_fail++;
          $display("FAIL rr_burst[%0d]: got dir=%0d len=%0d, expected dir=%0d len=4",
                   k, dir[k], len[k], k % 2);
        end
      end
    end
    n_tests++;
    if (viol != 0) begin
      n_fail++;
      $display("FAIL rr_oe_overlap: got %0d cycles, expected 0", viol);
    end
    n_tests++;
    if (gapbad != 0) begin
      n_fail++;
      $display("FAIL rr_turn_gap: got %0d missing turnarounds, expected 0", gapbad);
    end
  endtask

  task automatic test_single_byte();
    logic [2:0] exp_pat [4];
    int t;
    exp_pat = '{3'b101, 3'b100, 3'b111, 3'b011};
    start_test();
    rx_ready[2] = 1'b1;
    rx_base[2]  = 8'h60;
    rx_lim[2]   = 3;
    t = 0;
    while (busy[2] !== 1'b1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    for (int k = 0; k < 12; k++) begin
      n_tests++;
      if ({busy[2], oe[2], rd[2]} !== exp_pat[k % 4]) begin
        n_fail++;
        $display("FAIL sb_seq[%0d]: got busy,oe,rd=%b, expected %b",
                 k, {busy[2], oe[2], rd[2]}, exp_pat[k % 4]);
      end
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    n_tests++;
    if (rx_n[2] != 3 || rx_idx[2] != 3) begin
      n_fail++;
      $display("FAIL sb_count: got captured=%0d delivered=%0d, expected 3 and 3", rx_idx[2], rx_n[2]);
    end
    n_tests++;
    if (rx_got[2][2] !== 8'h62) begin
      n_fail++;
      $display("FAIL sb_last: got %h, expected 62", rx_got[2][2]);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_burst();
    test_rx_burst();
    test_rx_backpressure();
    test_tx_stall();
    test_arb_rr();
    test_single_byte();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion by 1 ms, expected completion");
    $fatal(1, "timeout");
  end

endmodule
